// File: rtl/ctrl_pkt_decoder_pkg.sv
// Shared field positions, widths and types for the control packet decoder.
// Packet layout: [0] input/ack, [1] filter/ifmap, [2] timestep, payload above.
package ctrl_pkg;

    localparam int TYPE_BIT     = 0;
    localparam int CLASS_BIT    = 1;
    localparam int TS_BIT       = 2;
    localparam int FIL_SIZE_LSB = 3;
    localparam int IF_SIZE_LSB  = 3;
    localparam int NODE_LSB     = 1;

    localparam int FIL_SIZE_W = 2;
    localparam int IF_SIZE_W  = 6;
    localparam int NODE_W     = 4;

    function automatic int PKT_W(input int fw);
        return 5 * fw + 5;
    endfunction

    typedef enum logic {
        NO_FILTER,
        HAVE_FILTER
    } ord_state_t;

    typedef enum logic [1:0] {
        PK_ACK,
        PK_IFMAP,
        PK_FILTER
    } pkt_class_t;

endpackage

// File: rtl/ctrl_pkt_decoder_credit_counter.sv
// Saturating per-PE credit counter; one token lane with valid/ready.
// ovf pulses when an ack lands on a full counter that is not draining.
module credit_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic tok_ready,
    output logic tok_valid,
    output logic ovf
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic             dec;

    assign tok_valid = (cnt_q != '0);
    assign dec       = tok_valid && tok_ready;
    assign ovf       = inc && !dec && (cnt_q == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && !dec && (cnt_q != MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ctrl_pkt_decoder.sv
// Control-unit front end: classifies packets, registers filter/ifmap words,
// enforces filter-before-ifmap per timestep and turns PE acks into credits.
module ctrl_pkt_decoder
    import ctrl_pkg::*;
#(
    parameter int FILTER_WIDTH = 8,
    parameter int NUM_PE       = 14,
    parameter int CNT_W        = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PKT_W(FILTER_WIDTH)-1:0] in_pkt,
    output logic                          fil_valid,
    input  logic                          fil_ready,
    output logic [5*FILTER_WIDTH-1:0]     fil_data,
    output logic [FIL_SIZE_W-1:0]         fil_size,
    output logic                          fil_ts,
    output logic                          if_valid,
    input  logic                          if_ready,
    output logic [5*FILTER_WIDTH-5:0]     if_data,
    output logic [IF_SIZE_W-1:0]          if_size,
    output logic                          if_ts,
    output logic [NUM_PE-1:0]             tok_valid,
    input  logic [NUM_PE-1:0]             tok_ready,
    output logic                          err_order,
    output logic                          err_node,
    output logic                          err_ovf
);

    localparam int PW  = PKT_W(FILTER_WIDTH);
    localparam int FDW = 5 * FILTER_WIDTH;
    localparam int IDW = 5 * FILTER_WIDTH - 4;
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_PE - 1);

    pkt_class_t        pkt_class;
    ord_state_t        state_q, state_d;
    logic              lts_q, lts_d;
    logic              ts;
    logic [NODE_W-1:0] node;
    logic              node_ok;
    logic              if_drop;
    logic              acc;
    logic              fil_load, if_load, if_bad, ack_acc;
    logic [NUM_PE-1:0] inc_vec, ovf_vec;

    assign ts      = in_pkt[TS_BIT];
    assign node    = in_pkt[NODE_LSB +: NODE_W];
    assign node_ok = (node <= LAST_NODE);
    assign if_drop = (state_q == NO_FILTER) || (ts != lts_q);

    always_comb begin
        pkt_class = PK_ACK;
        unique case (1'b1)
            !in_pkt[TYPE_BIT]:
                pkt_class = PK_ACK;
            in_pkt[TYPE_BIT] && in_pkt[CLASS_BIT]:
                pkt_class = PK_FILTER;
            in_pkt[TYPE_BIT] && !in_pkt[CLASS_BIT]:
                pkt_class = PK_IFMAP;
        endcase
    end

    // A doomed ifmap is swallowed even when the ifmap slot is full.
    always_comb begin
        in_ready = 1'b1;
        unique case (pkt_class)
            PK_FILTER: in_ready = !fil_valid || fil_ready;
            PK_IFMAP:  in_ready = if_drop || !if_valid || if_ready;
            default:   in_ready = 1'b1;
        endcase
    end

    assign acc      = in_valid && in_ready;
    assign fil_load = acc && (pkt_class == PK_FILTER);
    assign if_load  = acc && (pkt_class == PK_IFMAP) && !if_drop;
    assign if_bad   = acc && (pkt_class == PK_IFMAP) && if_drop;
    assign ack_acc  = acc && (pkt_class == PK_ACK);

    always_comb begin
        state_d = state_q;
        lts_d   = lts_q;
        if (fil_load) begin
            state_d = HAVE_FILTER;
            lts_d   = ts;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NO_FILTER;
            lts_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lts_q   <= lts_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fil_valid <= 1'b0;
            fil_data  <= '0;
            fil_size  <= '0;
            fil_ts    <= 1'b0;
        end else if (fil_load) begin
            fil_valid <= 1'b1;
            fil_data  <= in_pkt[PW-1 -: FDW];
            fil_size  <= in_pkt[FIL_SIZE_LSB +: FIL_SIZE_W];
            fil_ts    <= ts;
        end else if (fil_ready) begin
            fil_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_data  <= '0;
            if_size  <= '0;
            if_ts    <= 1'b0;
        end else if (if_load) begin
            if_valid <= 1'b1;
            if_data  <= in_pkt[PW-1 -: IDW];
            if_size  <= in_pkt[IF_SIZE_LSB +: IF_SIZE_W];
            if_ts    <= ts;
        end else if (if_ready) begin
            if_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_PE; i++) begin : g_cc
        assign inc_vec[i] = ack_acc && (node == NODE_W'(i));

        credit_counter #(
            .CNT_W(CNT_W)
        ) u_cc (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc_vec[i]),
            .tok_ready(tok_ready[i]),
            .tok_valid(tok_valid[i]),
            .ovf      (ovf_vec[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_order <= 1'b0;
            err_node  <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            if (if_bad)              err_order <= 1'b1;
            if (ack_acc && !node_ok) err_node  <= 1'b1;
            if (|ovf_vec)            err_ovf   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_pkt_decoder.sv
// Directed plus random checks of ctrl_pkt_decoder against a
// cycle-level behavioural model of slots, ordering and credits.
module tb_ctrl_pkt_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [44:0] in_pkt;
    logic        fil_valid;
    logic        fil_ready;
    logic [39:0] fil_data;
    logic [1:0]  fil_size;
    logic        fil_ts;
    logic        if_valid;
    logic        if_ready;
    logic [35:0] if_data;
    logic [5:0]  if_size;
    logic        if_ts;
    logic [13:0] tok_valid;
    logic [13:0] tok_ready;
    logic        err_order;
    logic        err_node;
    logic        err_ovf;

    int total = 0;
    int bad   = 0;

    logic        m_fv, m_fts, m_iv, m_its;
    logic [39:0] m_fd;
    logic [1:0]  m_fs;
    logic [35:0] m_id;
    logic [5:0]  m_is;
    bit          m_have, m_lts, m_eo, m_en, m_ev;
    int          m_cnt[14];
    bit          last_acc;

    ctrl_pkt_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pkt   (in_pkt),
        .fil_valid(fil_valid),
        .fil_ready(fil_ready),
        .fil_data (fil_data),
        .fil_size (fil_size),
        .fil_ts   (fil_ts),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_data  (if_data),
        .if_size  (if_size),
        .if_ts    (if_ts),
        .tok_valid(tok_valid),
        .tok_ready(tok_ready),
        .err_order(err_order),
        .err_node (err_node),
        .err_ovf  (err_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [44:0] fpkt(input logic ts, input logic [1:0] sz,
                                         input logic [39:0] d);
        return {d, sz, ts, 2'b11};
    endfunction

    function automatic logic [44:0] ipkt(input logic ts, input logic [5:0] sz,
                                         input logic [35:0] d);
        return {d, sz, ts, 2'b01};
    endfunction

    function automatic logic [44:0] apkt(input logic [3:0] n, input logic [39:0] j);
        return {j, n, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_fv = 0; m_fd = '0; m_fs = '0; m_fts = 0;
        m_iv = 0; m_id = '0; m_is = '0; m_its = 0;
        m_have = 0; m_lts = 0; m_eo = 0; m_en = 0; m_ev = 0;
        for (int i = 0; i < 14; i++) m_cnt[i] = 0;
    endtask

    function automatic logic [13:0] m_tok();
        logic [13:0] t;
        for (int i = 0; i < 14; i++) t[i] = (m_cnt[i] != 0);
        return t;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".fil_valid"}, 64'(fil_valid), 64'(m_fv));
        if (m_fv) begin
            chk({tag, ".fil_data"}, 64'(fil_data), 64'(m_fd));
            chk({tag, ".fil_size"}, 64'(fil_size), 64'(m_fs));
            chk({tag, ".fil_ts"}, 64'(fil_ts), 64'(m_fts));
        end
        chk({tag, ".if_valid"}, 64'(if_valid), 64'(m_iv));
        if (m_iv) begin
            chk({tag, ".if_data"}, 64'(if_data), 64'(m_id));
            chk({tag, ".if_size"}, 64'(if_size), 64'(m_is));
            chk({tag, ".if_ts"}, 64'(if_ts), 64'(m_its));
        end
        chk({tag, ".tok_valid"}, 64'(tok_valid), 64'(m_tok()));
        chk({tag, ".err_order"}, 64'(err_order), 64'(m_eo));
        chk({tag, ".err_node"}, 64'(err_node), 64'(m_en));
        chk({tag, ".err_ovf"}, 64'(err_ovf), 64'(m_ev));
    endtask

    // One clock: drive, check in_ready, advance the model, check outputs.
    task automatic cycle(input logic v, input logic [44:0] p, input logic fr,
                         input logic ir, input logic [13:0] tr, input string tag);
        logic er, acc, drop;
        int   n, nd;
        int   nc[14];
        in_valid  = v;
        in_pkt    = p;
        fil_ready = fr;
        if_ready  = ir;
        tok_ready = tr;
        #1;
        drop = !m_have || (p[2] != m_lts);
        if (!p[0])     er = 1'b1;
        else if (p[1]) er = !m_fv || fr;
        else           er = drop || !m_iv || ir;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(er));
        acc = v && er;
        last_acc = acc;
        nd = int'(p[4:1]);
        for (int i = 0; i < 14; i++) begin
            n = m_cnt[i];
            if (n > 0 && tr[i]) n = n - 1;
            if (acc && !p[0] && nd == i) n = n + 1;
            if (n > 3) begin
                n = 3;
                m_ev = 1;
            end
            nc[i] = n;
        end
        for (int i = 0; i < 14; i++) m_cnt[i] = nc[i];
        if (acc && !p[0] && nd >= 14) m_en = 1;
        if (m_fv && fr) m_fv = 0;
        if (acc && p[0] && p[1]) begin
            m_fv = 1; m_fd = p[44:5]; m_fs = p[4:3]; m_fts = p[2];
            m_have = 1; m_lts = p[2];
        end
        if (m_iv && ir) m_iv = 0;
        if (acc && p[0] && !p[1]) begin
            if (drop) m_eo = 1;
            else begin
                m_iv = 1; m_id = p[44:9]; m_is = p[8:3]; m_its = p[2];
            end
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    initial begin
        logic [44:0] rp;
        logic        rv;
        logic [3:0]  rn;
        in_valid = 0; in_pkt = '0; fil_ready = 0; if_ready = 0;
        tok_ready = '0; rst = 1; last_acc = 0;
        m_reset();
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.fil_data", 64'(fil_data), 64'd0);
        chk("rst.if_data", 64'(if_data), 64'd0);
        chk("rst.sizes", 64'({fil_size, if_size, fil_ts, if_ts}), 64'd0);
        check_outs("rst");
        @(posedge clk);
        #1;
        rst = 0;

        cycle(1, ipkt(1'b0, 6'd1, 36'h123), 1, 1, '0, "s1_early_ifmap");
        chk("s1.err_order", 64'(err_order), 64'd1);

        cycle(1, fpkt(1'b0, 2'b11, 40'h0102030405), 1, 1, '0, "s2_filter");
        chk("s2.fil_data", 64'(fil_data), 64'h0102030405);
        chk("s2.fil_size", 64'(fil_size), 64'd3);
        cycle(1, ipkt(1'b0, 6'd5, 36'hABCDE), 1, 1, '0, "s2_ifmap");
        chk("s2.if_valid", 64'(if_valid), 64'd1);
        chk("s2.if_size", 64'(if_size), 64'd5);

        cycle(1, fpkt(1'b1, 2'b01, 40'hAA), 0, 1, '0, "s3_first");
        cycle(1, fpkt(1'b1, 2'b10, 40'hBB), 0, 1, '0, "s3_stall0");
        cycle(1, fpkt(1'b1, 2'b10, 40'hBB), 0, 1, '0, "s3_stall1");
        cycle(1, apkt(4'd3, 40'hFFFF), 0, 1, '0, "s3_ack3");
        chk("s3.tok3", 64'(tok_valid[3]), 64'd1);
        cycle(1, fpkt(1'b1, 2'b10, 40'hBB), 0, 1, '0, "s3_stall2");
        cycle(1, fpkt(1'b1, 2'b10, 40'hBB), 1, 1, '0, "s3_release");
        chk("s3.fil_data", 64'(fil_data), 64'hBB);
        cycle(0, '0, 1, 1, '0, "s3_idle");

        for (int k = 0; k < 4; k++) begin
            cycle(1, apkt(4'd7, 40'h0), 1, 1, '0, "s4_ack7");
            chk("s4.err_ovf", 64'(err_ovf), 64'(k == 3));
        end
        for (int k = 0; k < 3; k++) begin
            cycle(0, '0, 1, 1, 14'h0080, "s4_drain");
            chk("s4.tok7", 64'(tok_valid[7]), 64'(k < 2));
        end

        cycle(1, apkt(4'd7, 40'h0), 1, 1, '0, "s5_ack");
        cycle(1, apkt(4'd7, 40'h0), 1, 1, 14'h0080, "s5_same");
        chk("s5.tok7", 64'(tok_valid[7]), 64'd1);
        cycle(0, '0, 1, 1, 14'h0080, "s5_drain");
        chk("s5.tok7_empty", 64'(tok_valid[7]), 64'd0);
        cycle(1, apkt(4'd14, 40'h0), 1, 1, '0, "s5_badnode");
        chk("s5.err_node", 64'(err_node), 64'd1);

        cycle(1, fpkt(1'b0, 2'b00, 40'h55), 0, 1, '0, "s6_fil");
        cycle(1, apkt(4'd2, 40'h0), 0, 1, '0, "s6_ack2a");
        cycle(1, apkt(4'd2, 40'h0), 0, 1, '0, "s6_ack2b");
        #3;
        rst = 1;
        #1;
        m_reset();
        chk("s6.fil_data", 64'(fil_data), 64'd0);
        chk("s6.in_ready", 64'(in_ready), 64'd1);
        check_outs("s6_async_rst");
        @(posedge clk);
        #1;
        rst = 0;
        cycle(1, ipkt(1'b0, 6'd2, 36'h77), 1, 1, '0, "s6_ifmap");
        chk("s6.if_valid", 64'(if_valid), 64'd0);

        rv = 0;
        rp = '0;
        for (int c = 0; c < 400; c++) begin
            if (!(rv && !last_acc)) begin
                rv = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 2))
                    0: begin
                        rn = 4'($urandom_range(0, 15));
                        rp = apkt(rn, 40'({$urandom, $urandom}));
                    end
                    1: rp = ipkt(1'($urandom), 6'($urandom), 36'({$urandom, $urandom}));
                    default: rp = fpkt(1'($urandom), 2'($urandom), 40'({$urandom, $urandom}));
                endcase
            end
            cycle(rv, rp, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  14'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
